johnson_sequencer: RTL

- Command-driven controller that sequences an internal WIDTH-bit Johnson (twisted-ring) counter.
- Supports free-run, N-step burst, stop and clear, with selectable direction and a programmable step-rate prescaler.
- Sits between the top-level input/bidirectional pins and the pattern outputs.
- Pattern period is 2*WIDTH steps.

---
 rtl/johnson_sequencer_pkg.sv | 18 +
 rtl/johnson_sequencer_if.sv | 11 +
 rtl/johnson_core.sv | 25 ++
 rtl/johnson_sequencer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/johnson_sequencer_pkg.sv
// Shared types and constants for the Johnson pattern sequencer.
package johnson_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10
  } state_t;

  localparam logic [1:0] OP_STOP   = 2'b00;
  localparam logic [1:0] OP_RUN    = 2'b01;
  localparam logic [1:0] OP_STEP_N = 2'b10;
  localparam logic [1:0] OP_CLEAR  = 2'b11;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/johnson_sequencer_if.sv
// Command handshake bundle for the Johnson sequencer; cmd_ready is driven by the slave.
interface johnson_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_dir;
  logic [7:0] cmd_count;

  modport master (output cmd_valid, cmd_op, cmd_dir, cmd_count, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_dir, cmd_count, output cmd_ready);
endinterface

// File: rtl/johnson_core.sv
// WIDTH-bit twisted-ring register: shifts one position per step, complementing the bit
// that wraps around. Reset and clear both force the all-zeros code.
module johnson_core
  import johnson_sequencer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             r,
  input  logic             step,
  input  logic             dir,
  input  logic             clear,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (r || clear) begin
      q <= '0;
    end else if (step) begin
      if (dir == DIR_REV) q <= {~q[0], q[WIDTH-1:1]};
      else                q <= {q[WIDTH-2:0], ~q[WIDTH-1]};
    end
  end

endmodule

// File: rtl/johnson_sequencer.sv
// Command-driven Johnson pattern sequencer: FSM, step-rate prescaler and burst counter.
// Optional wrap pulse / wrap counter outputs when JOHNSON_SEQUENCER_WRAP_EN is defined.
module johnson_sequencer
  import johnson_sequencer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  r,
  johnson_sequencer_if.slave    cmd,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      out,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            state
`ifdef JOHNSON_SEQUENCER_WRAP_EN
  ,
  output logic                  wrap,
  output logic [7:0]            wrap_cnt
`endif
);

  state_t                state_q, state_d;
  logic                  dir_q, dir_d;
  logic [7:0]            rem_q, rem_d;
  logic [PRESCALE_W-1:0] psc_cnt, psc_d;
  logic                  done_d;
  logic                  step_en, clear_en, tick;

  assign cmd.cmd_ready = 1'b1;
  assign tick          = (psc_cnt == prescale);
  assign busy          = (state_q != IDLE);
  assign state         = state_q;

  always_ff @(posedge clk) begin
    if (r) begin
      state_q <= IDLE;
      dir_q   <= DIR_FWD;
      rem_q   <= '0;
      psc_cnt <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      psc_cnt <= psc_d;
      done    <= done_d;
    end
  end

  // Accepted commands win over a coincident tick, so that tick never steps.
  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    rem_d    = rem_q;
    psc_d    = psc_cnt;
    done_d   = 1'b0;
    step_en  = 1'b0;
    clear_en = 1'b0;
    if (cmd.cmd_valid) begin
      psc_d = '0;
      case (cmd.cmd_op)
        OP_STOP: state_d = IDLE;
        OP_RUN: begin
          dir_d   = cmd.cmd_dir;
          state_d = RUN;
        end
        OP_STEP_N: begin
          if (cmd.cmd_count != 8'd0) begin
            dir_d   = cmd.cmd_dir;
            rem_d   = cmd.cmd_count;
            state_d = STEP;
          end else begin
            rem_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        OP_CLEAR: begin
          clear_en = 1'b1;
          state_d  = IDLE;
        end
      endcase
    end else begin
      case (state_q)
        RUN: begin
          if (tick) begin
            step_en = 1'b1;
            psc_d   = '0;
          end else begin
            psc_d = psc_cnt + PRESCALE_W'(1);
          end
        end
        STEP: begin
          if (tick) begin
            step_en = 1'b1;
            psc_d   = '0;
            rem_d   = rem_q - 8'd1;
            if (rem_q == 8'd1) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            psc_d = psc_cnt + PRESCALE_W'(1);
          end
        end
        default: begin
          psc_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  johnson_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .r     (r),
    .step  (step_en),
    .dir   (dir_q),
    .clear (clear_en),
    .q     (out)
  );

`ifdef JOHNSON_SEQUENCER_WRAP_EN
  // Only 100..0 (forward) or 0..01 (reverse) can step onto all-zeros.
  localparam logic [WIDTH-1:0] PRE_ZERO_FWD = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] PRE_ZERO_REV = {{(WIDTH-1){1'b0}}, 1'b1};
  logic lands_zero;

  assign lands_zero = step_en && ((dir_q == DIR_REV) ? (out == PRE_ZERO_REV)
                                                     : (out == PRE_ZERO_FWD));

  always_ff @(posedge clk) begin
    if (r) begin
      wrap     <= 1'b0;
      wrap_cnt <= '0;
    end else begin
      wrap <= lands_zero;
      if (clear_en)                             wrap_cnt <= '0;
      else if (lands_zero && wrap_cnt != 8'hFF) wrap_cnt <= wrap_cnt + 8'd1;
    end
  end
`endif

endmodule
